// File: rtl/axil_reg_init_seq.sv
// AXI4-Lite master that writes C_NUM_REGS config words, reads each back and checks it; reports pass/err/fail_idx.
// Latency: about 5 cycles per register with a zero-wait slave; all VALIDs are held until handshake, and each wait is bounded by C_TIMEOUT.
module axil_reg_init_seq #(
  parameter logic [31:0] C_BASE_ADDR = 32'h0000_0000,
  parameter int          C_NUM_REGS  = 4,
  parameter int          C_TIMEOUT   = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      start,
  input  logic [32*C_NUM_REGS-1:0]  cfg_data,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [1:0]                err_code,
  output logic [7:0]                fail_idx,
  output logic [31:0]               M_AXI_AWADDR,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [31:0]               M_AXI_WDATA,
  output logic [3:0]                M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [31:0]               M_AXI_ARADDR,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [31:0]               M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  localparam int TW = $clog2(C_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WRESP, S_RADDR, S_RDATA, S_NEXT, S_FIN
  } state_t;

  state_t        state;
  logic [7:0]    k;
  logic [7:0]    k_nx;
  logic [TW-1:0] wdog;
  logic          aw_ok;
  logic          w_ok;
  logic          aw_hs;
  logic          w_hs;
  logic          wr_fin;
  logic          tmo;
  logic          last_reg;
  logic [31:0]   cfg_word;
  logic [31:0]   cfg_word_nx;
  logic          abort_req;
  logic [1:0]    abort_code;
  logic          unused_resp_lsb;

  function automatic logic [31:0] reg_addr(input logic [7:0] idx);
    return C_BASE_ADDR + {22'd0, idx, 2'b00};
  endfunction

  assign M_AXI_WSTRB     = 4'hF;
  assign unused_resp_lsb = M_AXI_BRESP[0] ^ M_AXI_RRESP[0];

  assign aw_hs       = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs        = M_AXI_WVALID & M_AXI_WREADY;
  assign wr_fin      = (aw_ok | aw_hs) & (w_ok | w_hs);
  assign tmo         = (wdog == TW'(C_TIMEOUT - 1));
  assign k_nx        = k + 8'd1;
  assign last_reg    = (k == 8'(C_NUM_REGS - 1));
  assign cfg_word    = cfg_data[32*k +: 32];
  assign cfg_word_nx = cfg_data[32*k_nx +: 32];

  // A completing handshake in the same cycle as the watchdog expiry wins over the timeout.
  always_comb begin
    abort_req  = 1'b0;
    abort_code = 2'b00;
    case (state)
      S_WR: begin
        if (!wr_fin && tmo) begin
          abort_req  = 1'b1;
          abort_code = 2'b11;
        end
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP[1]) begin
            abort_req  = 1'b1;
            abort_code = 2'b01;
          end
        end else if (tmo) begin
          abort_req  = 1'b1;
          abort_code = 2'b11;
        end
      end
      S_RADDR: begin
        if (!M_AXI_ARREADY && tmo) begin
          abort_req  = 1'b1;
          abort_code = 2'b11;
        end
      end
      S_RDATA: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP[1]) begin
            abort_req  = 1'b1;
            abort_code = 2'b01;
          end else if (M_AXI_RDATA != cfg_word) begin
            abort_req  = 1'b1;
            abort_code = 2'b10;
          end
        end else if (tmo) begin
          abort_req  = 1'b1;
          abort_code = 2'b11;
        end
      end
      default: begin
        abort_req  = 1'b0;
        abort_code = 2'b00;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= S_IDLE;
      k             <= '0;
      wdog          <= '0;
      aw_ok         <= 1'b0;
      w_ok          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_code      <= 2'b00;
      fail_idx      <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_req) begin
        state         <= S_FIN;
        wdog          <= '0;
        busy          <= 1'b0;
        done          <= 1'b1;
        pass          <= 1'b0;
        err_code      <= abort_code;
        fail_idx      <= k;
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            wdog <= '0;
            if (start) begin
              state         <= S_WR;
              busy          <= 1'b1;
              pass          <= 1'b0;
              err_code      <= 2'b00;
              fail_idx      <= '0;
              k             <= '0;
              aw_ok         <= 1'b0;
              w_ok          <= 1'b0;
              M_AXI_AWADDR  <= reg_addr(8'd0);
              M_AXI_ARADDR  <= reg_addr(8'd0);
              M_AXI_WDATA   <= cfg_data[31:0];
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
            end
          end
          S_WR: begin
            if (aw_hs) begin
              M_AXI_AWVALID <= 1'b0;
              aw_ok         <= 1'b1;
            end
            if (w_hs) begin
              M_AXI_WVALID <= 1'b0;
              w_ok         <= 1'b1;
            end
            if (wr_fin) begin
              state        <= S_WRESP;
              wdog         <= '0;
              M_AXI_BREADY <= 1'b1;
            end else begin
              wdog <= wdog + TW'(1);
            end
          end
          S_WRESP: begin
            if (M_AXI_BVALID) begin
              state         <= S_RADDR;
              wdog          <= '0;
              M_AXI_BREADY  <= 1'b0;
              M_AXI_ARVALID <= 1'b1;
            end else begin
              wdog <= wdog + TW'(1);
            end
          end
          S_RADDR: begin
            if (M_AXI_ARREADY) begin
              state         <= S_RDATA;
              wdog          <= '0;
              M_AXI_ARVALID <= 1'b0;
              M_AXI_RREADY  <= 1'b1;
            end else begin
              wdog <= wdog + TW'(1);
            end
          end
          S_RDATA: begin
            if (M_AXI_RVALID) begin
              state        <= S_NEXT;
              wdog         <= '0;
              M_AXI_RREADY <= 1'b0;
            end else begin
              wdog <= wdog + TW'(1);
            end
          end
          S_NEXT: begin
            wdog <= '0;
            if (last_reg) begin
              state <= S_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              // Next register's address and data are loaded here so they are stable from the first VALID cycle.
              state         <= S_WR;
              k             <= k_nx;
              aw_ok         <= 1'b0;
              w_ok          <= 1'b0;
              M_AXI_AWADDR  <= reg_addr(k_nx);
              M_AXI_ARADDR  <= reg_addr(k_nx);
              M_AXI_WDATA   <= cfg_word_nx;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
            end
          end
          S_FIN: begin
            state <= S_IDLE;
            wdog  <= '0;
          end
          default: begin
            state <= S_IDLE;
            wdog  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axil_reg_init_seq.sv
// Directed bench for axil_reg_init_seq: a behavioural AXI-Lite slave with per-register skew and fault knobs.
// Expected values are hand-derived from the configured words and the fault scenario of each run.
module tb_axil_reg_init_seq;
  localparam int          NR   = 4;
  localparam int          TMO  = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic          tb_ACLK = 1'b0;
  logic          ARESETN;
  logic          start;
  logic [32*NR-1:0] cfg_data;
  logic          busy, done, pass;
  logic [1:0]    err_code;
  logic [7:0]    fail_idx;
  logic [31:0]   M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [3:0]    M_AXI_WSTRB;
  logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
  logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic          M_AXI_RVALID, M_AXI_RREADY;

  always #5 tb_ACLK = ~tb_ACLK;

  axil_reg_init_seq #(.C_BASE_ADDR(BASE), .C_NUM_REGS(NR), .C_TIMEOUT(TMO)) dut (
    .ACLK(tb_ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .pass(pass), .err_code(err_code), .fail_idx(fail_idx),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model state and fault knobs
  logic [31:0] mem [NR];
  int          wr_cnt [NR];
  int          rd_cnt [NR];
  int          aw_dly [NR] = '{0, 3, 0, 2};
  int          w_dly  [NR] = '{0, 0, 3, 2};
  logic [32:0] acc_log [$];
  int  aw_hs_cnt, w_hs_cnt, done_cnt, overlap_cnt;
  int  bresp_err_idx = -1, rzero_idx = -1, ar_stuck_idx = -1;
  bit  skew = 1'b0;
  logic        aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0, ar_prev = 1'b0;
  logic [31:0] aw_a, w_d, r_d;
  logic [1:0]  b_r = 2'b00;
  int  cyc = 0, ar_rise_cyc = 0, done_cyc = 0;

  initial begin
    forever begin
      @(posedge tb_ACLK);
      cyc++;
      if (!ARESETN) begin
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0; ar_prev = 1'b0;
      end else begin
        if (busy && done) overlap_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (M_AXI_ARVALID && !ar_prev) ar_rise_cyc = cyc;
        ar_prev = M_AXI_ARVALID;
        if (M_AXI_BVALID && M_AXI_BREADY) b_pend = 1'b0;
        if (M_AXI_RVALID && M_AXI_RREADY) r_pend = 1'b0;
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_got = 1'b1; aw_a = M_AXI_AWADDR; aw_hs_cnt++; end
        if (M_AXI_WVALID && M_AXI_WREADY) begin w_got = 1'b1; w_d = M_AXI_WDATA; w_hs_cnt++; end
        if (aw_got && w_got) begin
          automatic int idx = int'(aw_a[9:2]);
          if (idx < NR) begin wr_cnt[idx]++; mem[idx] = w_d; end
          b_r    = (idx == bresp_err_idx) ? 2'b10 : 2'b00;
          b_pend = 1'b1;
          acc_log.push_back({1'b0, aw_a});
          aw_got = 1'b0; w_got = 1'b0;
        end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          automatic int idx = int'(M_AXI_ARADDR[9:2]);
          if (idx < NR) rd_cnt[idx]++;
          r_d    = (idx == rzero_idx || idx >= NR) ? 32'h0 : mem[idx];
          r_pend = 1'b1;
          acc_log.push_back({1'b1, M_AXI_ARADDR});
        end
      end
    end
  end

  initial begin
    automatic int aw_wait = 0;
    automatic int w_wait  = 0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    forever begin
      @(negedge tb_ACLK);
      begin
        automatic int ai = int'(M_AXI_AWADDR[3:2]);
        if (M_AXI_AWVALID) begin
          M_AXI_AWREADY = (aw_wait >= (skew ? aw_dly[ai] : 0));
          aw_wait++;
        end else begin
          M_AXI_AWREADY = 1'b0; aw_wait = 0;
        end
        if (M_AXI_WVALID) begin
          M_AXI_WREADY = (w_wait >= (skew ? w_dly[ai] : 0));
          w_wait++;
        end else begin
          M_AXI_WREADY = 1'b0; w_wait = 0;
        end
      end
      M_AXI_BVALID  = b_pend;
      M_AXI_BRESP   = b_r;
      M_AXI_ARREADY = M_AXI_ARVALID && (int'(M_AXI_ARADDR[9:2]) != ar_stuck_idx);
      M_AXI_RVALID  = r_pend;
      M_AXI_RDATA   = r_d;
      M_AXI_RRESP   = 2'b00;
    end
  end

  task automatic clear_stats();
    for (int i = 0; i < NR; i++) begin wr_cnt[i] = 0; rd_cnt[i] = 0; mem[i] = '0; end
    aw_hs_cnt = 0; w_hs_cnt = 0; done_cnt = 0; overlap_cnt = 0;
    acc_log.delete();
  endtask

  // Pulses start, optionally re-pulses it while busy, and waits (bounded) for done.
  task automatic run_seq(input string tag, input bit extra_start);
    bit got_done = 1'b0;
    clear_stats();
    @(negedge tb_ACLK); start = 1'b1;
    @(negedge tb_ACLK); start = 1'b0;
    check_val({tag, "_busy_after_start"}, {63'd0, busy}, 64'd1);
    check_val({tag, "_cleared_on_start"}, {53'd0, pass, err_code, fail_idx}, 64'd0);
    for (int i = 0; i < 400; i++) begin
      if (done) begin got_done = 1'b1; break; end
      start = extra_start && (i == 3);
      @(negedge tb_ACLK);
    end
    start = 1'b0;
    check_val({tag, "_done_seen"}, {63'd0, got_done}, 64'd1);
    check_val({tag, "_busy_with_done"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic check_result(input string tag, input logic p, input logic [1:0] e, input logic [7:0] f);
    check_val({tag, "_result"}, {53'd0, pass, err_code, fail_idx}, {53'd0, p, e, f});
  endtask

  task automatic settle(input string tag);
    repeat (4) @(negedge tb_ACLK);
    check_val({tag, "_one_done"}, 64'(done_cnt), 64'd1);
    check_val({tag, "_no_overlap"}, 64'(overlap_cnt), 64'd0);
  endtask

  logic [31:0] cfg_w [NR] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};

  initial begin
    ARESETN = 1'b0;
    start   = 1'b0;
    for (int i = 0; i < NR; i++) cfg_data[32*i +: 32] = cfg_w[i];
    repeat (3) @(negedge tb_ACLK);
    check_val("rst_ctrl", {48'd0, busy, done, pass, err_code, fail_idx, M_AXI_AWVALID, M_AXI_WVALID,
              M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 64'd0);
    check_val("rst_addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, 64'd0);
    check_val("rst_araddr", {32'd0, M_AXI_ARADDR}, 64'd0);
    check_val("wstrb", {60'd0, M_AXI_WSTRB}, 64'hF);
    ARESETN = 1'b1;
    repeat (3) @(negedge tb_ACLK);
    check_val("idle_no_start", {62'd0, busy, M_AXI_AWVALID}, 64'd0);

    // Zero-wait OKAY slave, start re-pulsed mid-run must be ignored
    run_seq("basic", 1'b1);
    check_result("basic", 1'b1, 2'b00, 8'd0);
    check_val("basic_log_len", 64'(acc_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < acc_log.size(); i++)
      check_val($sformatf("basic_log%0d", i), {31'd0, acc_log[i]}, {31'd0, (i % 2) == 1, 32'(4 * (i / 2))});
    for (int i = 0; i < NR; i++)
      check_val($sformatf("basic_mem%0d", i), {32'd0, mem[i]}, {32'd0, cfg_w[i]});
    settle("basic");

    // AW/W skew: same-cycle, W first, AW first, both late
    skew = 1'b1;
    run_seq("skew", 1'b0);
    check_result("skew", 1'b1, 2'b00, 8'd0);
    check_val("skew_hs_counts", {32'(aw_hs_cnt), 32'(w_hs_cnt)}, {32'd4, 32'd4});
    check_val("skew_wr_cnt", {wr_cnt[0][15:0], wr_cnt[1][15:0], wr_cnt[2][15:0], wr_cnt[3][15:0]},
              {16'd1, 16'd1, 16'd1, 16'd1});
    settle("skew");
    skew = 1'b0;

    // SLVERR write response on register 2
    bresp_err_idx = 2;
    run_seq("bresp", 1'b0);
    check_result("bresp", 1'b0, 2'b01, 8'd2);
    check_val("bresp_log_len", 64'(acc_log.size()), 64'd5);
    check_val("bresp_no_rd2_wr3", {32'(rd_cnt[2]), 32'(wr_cnt[3])}, 64'd0);
    settle("bresp");
    bresp_err_idx = -1;

    // Register 1 reads back zero
    rzero_idx = 1;
    run_seq("mism", 1'b0);
    check_result("mism", 1'b0, 2'b10, 8'd1);
    check_val("mism_untouched", {16'(wr_cnt[2]), 16'(wr_cnt[3]), 16'(rd_cnt[2]), 16'(rd_cnt[3])}, 64'd0);
    check_val("mism_log_len", 64'(acc_log.size()), 64'd4);
    settle("mism");
    rzero_idx = -1;

    // ARREADY stuck on register 3
    ar_stuck_idx = 3;
    run_seq("tmo", 1'b0);
    check_result("tmo", 1'b0, 2'b11, 8'd3);
    check_val("tmo_arvalid_low", {63'd0, M_AXI_ARVALID}, 64'd0);
    settle("tmo");
    check_val("tmo_latency", 64'(done_cyc - ar_rise_cyc), 64'd16);
    check_val("tmo_no_rd3", 64'(rd_cnt[3]), 64'd0);
    ar_stuck_idx = -1;

    // Reset while WVALID is high, then a fresh run
    clear_stats();
    @(negedge tb_ACLK); start = 1'b1;
    @(negedge tb_ACLK); start = 1'b0;
    check_val("rst2_wvalid_pre", {63'd0, M_AXI_WVALID}, 64'd1);
    ARESETN = 1'b0;
    #1;
    check_val("rst2_async_ctrl", {48'd0, busy, done, pass, err_code, fail_idx, M_AXI_AWVALID, M_AXI_WVALID,
              M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 64'd0);
    check_val("rst2_async_addr", {M_AXI_AWADDR, M_AXI_WDATA}, 64'd0);
    repeat (3) @(negedge tb_ACLK);
    ARESETN = 1'b1;
    repeat (4) @(negedge tb_ACLK);
    check_val("rst2_stay_idle", {62'd0, busy, M_AXI_AWVALID}, 64'd0);
    run_seq("rst2", 1'b0);
    check_result("rst2", 1'b1, 2'b00, 8'd0);
    check_val("rst2_log_len", 64'(acc_log.size()), 64'd8);
    settle("rst2");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end, limit 200000 reached");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/axil_reg_init_seq.md
AXIL_REG_INIT_SEQ -- requirements
Module: axil_reg_init_seq

Interface
REQ-001 SHALL have parameter C_BASE_ADDR, default 32'h0000_0000: byte address of register 0 in the target slave.
REQ-002 SHALL have parameter C_NUM_REGS, default 4, legal 1..256: number of 32-bit registers to load and check.
REQ-003 SHALL have parameter C_TIMEOUT, default 1024, legal ≥ 2: maximum cycles allowed for any single handshake wait.
REQ-004 SHALL have port ACLK  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port ARESETN  in  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port start  in  1  one-cycle pulse; starts a sequence when idle.
REQ-007 SHALL have port cfg_data  in  32*C_NUM_REGS  register k value at bits [32k+31:32k]; sampled per access, held stable by the user while busy.
REQ-008 SHALL have port busy  out  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  out  1  one-cycle pulse at sequence end.
REQ-010 SHALL have port pass  out  1  result of the last sequence; valid from done until the next accepted start.
REQ-011 SHALL have port err_code  out  2  00 none, 01 non-OKAY response, 10 readback mismatch, 11 timeout.
REQ-012 SHALL have port fail_idx  out  8  register index at which the sequence aborted; 0 when pass.
REQ-013 SHALL have port M_AXI_AWADDR  out  32  write address.
REQ-014 SHALL have port M_AXI_AWVALID  out  1  write address valid.
REQ-015 SHALL have port M_AXI_AWREADY  in  1  write address ready.
REQ-016 SHALL have port M_AXI_WDATA  out  32  write data.
REQ-017 SHALL have port M_AXI_WSTRB  out  4  constant 4'hF.
REQ-018 SHALL have port M_AXI_WVALID  out  1  write data valid.
REQ-019 SHALL have port M_AXI_WREADY  in  1  write data ready.
REQ-020 SHALL have port M_AXI_BRESP  in  2  write response.
REQ-021 SHALL have port M_AXI_BVALID  in  1  write response valid.
REQ-022 SHALL have port M_AXI_BREADY  out  1  write response ready.
REQ-023 SHALL have port M_AXI_ARADDR  out  32  read address.
REQ-024 SHALL have port M_AXI_ARVALID  out  1  read address valid.
REQ-025 SHALL have port M_AXI_ARREADY  in  1  read address ready.
REQ-026 SHALL have port M_AXI_RDATA  in  32  read data.
REQ-027 SHALL have port M_AXI_RRESP  in  2  read response.
REQ-028 SHALL have port M_AXI_RVALID  in  1  read data valid.
REQ-029 SHALL have port M_AXI_RREADY  out  1  read data ready.

Function
REQ-030 SHALL implement FSM IDLE -> WR -> WRESP -> RADDR -> RDATA -> NEXT -> (WR | FIN) -> IDLE; FIN asserts done for one cycle.
REQ-031 SHALL accept start only in IDLE; start while busy is ignored; accepted start clears pass, err_code and fail_idx and sets index k=0.
REQ-032 SHALL drive AWADDR = ARADDR = C_BASE_ADDR + 4*k (32-bit wrap) and WDATA = cfg_data word k, all registered and stable while the corresponding VALID is high.
REQ-033 SHALL in WR assert AWVALID and WVALID in the same cycle, drop each independently the cycle after its own handshake, and enter WRESP once both have handshaken, including same-cycle handshakes.
REQ-034 SHALL assert BREADY only in WRESP; on BVALID: BRESP[1]=0 (OKAY or EXOKAY) -> RADDR, otherwise err_code=01 and abort.
REQ-035 SHALL in RADDR hold ARVALID until ARREADY, then in RDATA hold RREADY until RVALID; no VALID is ever deasserted before its handshake.
REQ-036 SHALL on RVALID: RRESP[1]=1 -> err_code=01; RDATA != cfg_data word k -> err_code=10; both -> 01; either aborts.
REQ-037 SHALL in NEXT increment k; k reaching C_NUM_REGS -> FIN with pass=1, else WR; no extra idle cycles between registers beyond NEXT.
REQ-038 SHALL run a watchdog cleared on every state change; reaching C_TIMEOUT cycles in WR, WRESP, RADDR or RDATA sets err_code=11 and aborts.
REQ-039 SHALL on abort deassert all VALID/READY outputs, record fail_idx=k, go to FIN with pass=0; no further registers are accessed.
REQ-040 SHALL keep busy high in WR through NEXT; busy low in FIN and IDLE; done and busy never high together.

Reset
REQ-041 SHALL on ARESETN low, asynchronously, return to IDLE and clear busy, done, pass, err_code, fail_idx, all AXI VALID/READY outputs and the address/data registers to 0; reset mid-transaction abandons it without completion.
REQ-042 SHALL leave IDLE no earlier than the first start pulse sampled after ARESETN rises.

Verification
REQ-043 SHALL: C_NUM_REGS=4, base 0, data 0101FFFF/abcd0001/dead0011/beef0011, zero-wait OKAY slave -> 4 writes then readbacks at 0,4,8,C, done with pass=1, err_code=00.
REQ-044 SHALL: slave with random AWREADY/WREADY skew (W before AW, AW before W, same cycle) -> each accepted exactly once, pass=1.
REQ-045 SHALL: slave returns BRESP=SLVERR on register 2 -> no AR issued for 2, done, pass=0, err_code=01, fail_idx=2.
REQ-046 SHALL: register 1 reads back 0 -> err_code=10, fail_idx=1, registers 2-3 untouched.
REQ-047 SHALL: C_TIMEOUT=16, ARREADY stuck low on register 3 -> done 16 cycles after ARVALID rises, err_code=11, ARVALID low after abort.
REQ-048 SHALL: ARESETN low while WVALID high, then start again -> all outputs 0 during reset, fresh sequence completes with pass=1.
